// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine.
// The control FSM and the datapath both use this package.
//   gcd_state_e : control FSM states.
//   SEL_*       : 2-bit operand-register next-value selects.
//                 For selB, SEL_SUB is reserved and the datapath treats it as HOLD.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_SWAP = 2'd2;
  localparam logic [1:0] SEL_SUB  = 2'd3;

endpackage

// File: rtl/gcd_control.sv
// Control unit for an iterative (subtract/swap Euclid) GCD engine.
// It accepts operands over a val/rdy handshake, steers the datapath A/B
// register selects, and presents the result (datapath A) over a val/rdy
// handshake.
//
// Ports:
//   clk, rst_b       : clock (rising edge); asynchronous active-low reset.
//   ops_val/ops_rdy  : operand handshake. ops_rdy is a Moore output.
//   res_val/res_rdy  : result handshake. res_val is a Moore output.
//   selA, selB       : Mealy register selects, forced to HOLD while in reset.
//   curr_A, curr_B   : current datapath register values (unsigned, WL bits).
module gcd_control
  import gcd_pkg::*;
#(
  parameter int unsigned WL = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          ops_val,
  output logic          ops_rdy,
  input  logic          res_rdy,
  output logic          res_val,
  output logic [1:0]    selA,
  output logic [1:0]    selB,
  input  logic [WL-1:0] curr_A,
  input  logic [WL-1:0] curr_B
);

  gcd_state_e state_q;
  gcd_state_e state_d;
  logic       a_lt_b;
  logic       b_zero;

  assign a_lt_b = (curr_A < curr_B);
  assign b_zero = (curr_B == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    selA    = SEL_HOLD;
    selB    = SEL_HOLD;
    ops_rdy = 1'b0;
    res_val = 1'b0;

    case (state_q)
      IDLE: begin
        ops_rdy = 1'b1;
        if (ops_val) begin
          selA    = SEL_LOAD;
          selB    = SEL_LOAD;
          state_d = CALC;
        end
      end

      CALC: begin
        if (a_lt_b) begin
          selA = SEL_SWAP;
          selB = SEL_SWAP;
        end else if (!b_zero) begin
          selA = SEL_SUB;
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        res_val = 1'b1;
        if (res_rdy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The state register already sits in IDLE during reset. The IDLE load
    // select is Mealy on ops_val, so it has to be masked here to keep the
    // datapath from loading while reset is held.
    if (!rst_b) begin
      selA = SEL_HOLD;
      selB = SEL_HOLD;
    end
  end

endmodule

// File: tb/tb_gcd_control.sv
module tb_gcd_control;
  import gcd_pkg::*;

  localparam int unsigned WL = 8;

  logic          clk;
  logic          rst_b;
  logic          ops_val;
  logic          ops_rdy;
  logic          res_rdy;
  logic          res_val;
  logic [1:0]    selA;
  logic [1:0]    selB;
  logic [WL-1:0] curr_A;
  logic [WL-1:0] curr_B;

  // Behavioral datapath, with an override for forcing curr values directly.
  logic [WL-1:0] opA, opB;
  logic [WL-1:0] dpA, dpB;
  logic          ovr;
  logic [WL-1:0] fA, fB;

  assign curr_A = ovr ? fA : dpA;
  assign curr_B = ovr ? fB : dpB;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dpA <= '0;
      dpB <= '0;
    end else begin
      case (selA)
        SEL_LOAD: dpA <= opA;
        SEL_SWAP: dpA <= curr_B;
        SEL_SUB:  dpA <= curr_A - curr_B;
        default:  dpA <= dpA;
      endcase
      case (selB)
        SEL_LOAD: dpB <= opB;
        SEL_SWAP: dpB <= curr_A;
        default:  dpB <= dpB;
      endcase
    end
  end

  gcd_control #(.WL(WL)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .ops_val (ops_val),
    .ops_rdy (ops_rdy),
    .res_rdy (res_rdy),
    .res_val (res_val),
    .selA    (selA),
    .selB    (selB),
    .curr_A  (curr_A),
    .curr_B  (curr_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned res;
    int unsigned calc_cycles;
  } vec_t;

  typedef struct {
    logic [1:0] sa;
    logic [1:0] sb;
    int unsigned a_after;
    int unsigned b_after;
  } step_t;

  // Drive one operand pair through a full transaction with res_rdy high.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int unsigned exp;
    @(negedge clk);
    opA = v.a[WL-1:0];
    opB = v.b[WL-1:0];
    ops_val = 1'b1;
    res_rdy = 1'b1;
    #1;
    check($sformatf("v%0d_ops_rdy", idx), int'(ops_rdy), 1);
    @(posedge clk);
    sb.push_back(v.res);
    @(negedge clk);
    ops_val = 1'b0;
    #1;
    n = 0;
    while (!res_val && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
    check($sformatf("v%0d_calc_cycles", idx), n, int'(v.calc_cycles));
    if (res_val && sb.size() > 0) begin
      exp = sb.pop_front();
      check($sformatf("v%0d_result", idx), int'(curr_A), int'(exp));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle_after", idx), int'(ops_rdy), 1);
    end else begin
      check($sformatf("v%0d_res_val_seen", idx), int'(res_val), 1);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    vec_t  vecs[9];
    step_t steps[6];
    int unsigned exp;
    int n;

    vecs[0] = '{a: 0,   b: 0,   res: 0,  calc_cycles: 1};
    vecs[1] = '{a: 0,   b: 5,   res: 5,  calc_cycles: 2};
    vecs[2] = '{a: 7,   b: 0,   res: 7,  calc_cycles: 1};
    vecs[3] = '{a: 6,   b: 4,   res: 2,  calc_cycles: 6};
    vecs[4] = '{a: 12,  b: 18,  res: 6,  calc_cycles: 7};
    vecs[5] = '{a: 13,  b: 13,  res: 13, calc_cycles: 3};
    vecs[6] = '{a: 9,   b: 3,   res: 3,  calc_cycles: 5};
    vecs[7] = '{a: 255, b: 1,   res: 1,  calc_cycles: 257};
    vecs[8] = '{a: 1,   b: 255, res: 1,  calc_cycles: 258};

    steps[0] = '{sa: SEL_SUB,  sb: SEL_HOLD, a_after: 2, b_after: 4};
    steps[1] = '{sa: SEL_SWAP, sb: SEL_SWAP, a_after: 4, b_after: 2};
    steps[2] = '{sa: SEL_SUB,  sb: SEL_HOLD, a_after: 2, b_after: 2};
    steps[3] = '{sa: SEL_SUB,  sb: SEL_HOLD, a_after: 0, b_after: 2};
    steps[4] = '{sa: SEL_SWAP, sb: SEL_SWAP, a_after: 2, b_after: 0};
    steps[5] = '{sa: SEL_HOLD, sb: SEL_HOLD, a_after: 2, b_after: 0};

    rst_b = 1'b0; ops_val = 1'b0; res_rdy = 1'b0;
    opA = '0; opB = '0; ovr = 1'b0; fA = '0; fB = '0;

    // Reset state, including ops_val high: selects must stay HOLD.
    @(posedge clk);
    #1;
    check("rst_ops_rdy", int'(ops_rdy), 1);
    check("rst_res_val", int'(res_val), 0);
    ops_val = 1'b1;
    #1;
    check("rst_selA", int'(selA), 0);
    check("rst_selB", int'(selB), 0);
    @(negedge clk);
    ops_val = 1'b0;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("idle_stay_ops_rdy", int'(ops_rdy), 1);
    check("idle_stay_selA", int'(selA), 0);

    // Load, then forced curr values (6,8) give a swap.
    @(negedge clk);
    opA = 6; opB = 4; ops_val = 1'b1;
    #1;
    check("load_selA", int'(selA), int'(SEL_LOAD));
    check("load_selB", int'(selB), int'(SEL_LOAD));
    @(negedge clk);
    ops_val = 1'b0; ovr = 1'b1; fA = 6; fB = 8;
    #1;
    check("swap_ops_rdy", int'(ops_rdy), 0);
    check("swap_selA", int'(selA), int'(SEL_SWAP));
    check("swap_selB", int'(selB), int'(SEL_SWAP));
    ovr = 1'b0;
    do_reset();

    // Full GCD(6,4) step by step, then backpressure in DONE.
    @(negedge clk);
    opA = 6; opB = 4; ops_val = 1'b1; res_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("g64_load_A", int'(dpA), 6);
    check("g64_load_B", int'(dpB), 4);
    sb.push_back(2);
    @(negedge clk);
    ops_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("g64_s%0d_selA", i), int'(selA), int'(steps[i].sa));
      check($sformatf("g64_s%0d_selB", i), int'(selB), int'(steps[i].sb));
      @(posedge clk);
      #1;
      check($sformatf("g64_s%0d_A", i), int'(dpA), int'(steps[i].a_after));
      check($sformatf("g64_s%0d_B", i), int'(dpB), int'(steps[i].b_after));
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      ops_val = 1'b1;
      #1;
      check($sformatf("bp%0d_res_val", i), int'(res_val), 1);
      check($sformatf("bp%0d_ops_rdy", i), int'(ops_rdy), 0);
      check($sformatf("bp%0d_selA", i), int'(selA), 0);
      check($sformatf("bp%0d_selB", i), int'(selB), 0);
      @(negedge clk);
    end
    ops_val = 1'b0; res_rdy = 1'b1;
    #1;
    if (res_val && sb.size() > 0) begin
      exp = sb.pop_front();
      check("g64_result", int'(curr_A), int'(exp));
    end else begin
      check("g64_res_val", int'(res_val), 1);
    end
    @(posedge clk);
    #1;
    check("g64_idle_ops_rdy", int'(ops_rdy), 1);
    check("g64_idle_res_val", int'(res_val), 0);

    // Table-driven transactions.
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    opA = 255; opB = 1; ops_val = 1'b1; res_rdy = 1'b1;
    @(posedge clk);
    sb.push_back(1);
    @(negedge clk);
    ops_val = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_b = 1'b0;
    sb.delete();
    #1;
    check("midrst_ops_rdy", int'(ops_rdy), 1);
    check("midrst_res_val", int'(res_val), 0);
    check("midrst_selA", int'(selA), 0);
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      #1;
      if (res_val) n++;
    end
    check("midrst_no_result", n, 0);
    check("midrst_idle", int'(ops_rdy), 1);

    // Asynchronous reset while holding a result in DONE.
    @(negedge clk);
    opA = 7; opB = 0; ops_val = 1'b1; res_rdy = 1'b0;
    @(negedge clk);
    ops_val = 1'b0;
    @(negedge clk);
    #1;
    check("done_rst_pre_res_val", int'(res_val), 1);
    #2;
    rst_b = 1'b0;
    #1;
    check("done_rst_res_val", int'(res_val), 0);
    check("done_rst_ops_rdy", int'(ops_rdy), 1);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("done_rst_after", int'(res_val), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
